// File: rtl/if_fetch_if.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_if
// Brief    : Fetch-stage bundle: execute handshake, index registers, memory
//            read bus and the resolved-instruction result fields.
// Revision : 1.0 - initial release
// ============================================================================
interface if_fetch_if;
    logic        if_start;
    logic [15:0] pc_in;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [15:0] mem_addr;
    logic        mem_req;
    logic [7:0]  mem_data_in;
    logic        if_ready;
    logic [7:0]  opcode;
    logic [15:0] if_addr_in;
    logic [15:0] if_pc_next;
    logic        immediate_flag;
    logic [3:0]  addr_mode;

    // Execute stage plus memory model side
    modport master (
        output if_start, pc_in, x, y, mem_data_in,
        input  mem_addr, mem_req, if_ready, opcode, if_addr_in,
               if_pc_next, immediate_flag, addr_mode
    );

    // Fetch stage side
    modport slave (
        input  if_start, pc_in, x, y, mem_data_in,
        output mem_addr, mem_req, if_ready, opcode, if_addr_in,
               if_pc_next, immediate_flag, addr_mode
    );
endinterface
`default_nettype wire

// File: rtl/if_fetch.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch
// Brief    : 6502 instruction fetch and effective-address resolution stage.
// Revision : 1.0 - initial release
// ============================================================================
module if_fetch #(
    parameter logic [15:0] RESET_PC   = 16'hFFFC,
    parameter logic [7:0]  NOP_OPCODE = 8'hEA
) (
    input  logic      clk,
    input  logic      rst,
    if_fetch_if.slave bus
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_OP     = 3'd1;
    localparam logic [2:0] S_OPR_LO = 3'd2;
    localparam logic [2:0] S_OPR_HI = 3'd3;
    localparam logic [2:0] S_PTR_LO = 3'd4;
    localparam logic [2:0] S_PTR_HI = 3'd5;
    localparam logic [2:0] S_CALC   = 3'd6;

    localparam logic [1:0] P_ISSUE   = 2'd0;
    localparam logic [1:0] P_WAIT    = 2'd1;
    localparam logic [1:0] P_CAPTURE = 2'd2;

    localparam logic [3:0] M_IMPL = 4'd0;
    localparam logic [3:0] M_IMM  = 4'd1;
    localparam logic [3:0] M_ZP   = 4'd2;
    localparam logic [3:0] M_ZPX  = 4'd3;
    localparam logic [3:0] M_ZPY  = 4'd4;
    localparam logic [3:0] M_ABS  = 4'd5;
    localparam logic [3:0] M_ABSX = 4'd6;
    localparam logic [3:0] M_ABSY = 4'd7;
    localparam logic [3:0] M_INDX = 4'd8;
    localparam logic [3:0] M_INDY = 4'd9;
    localparam logic [3:0] M_IND  = 4'd10;
    localparam logic [3:0] M_REL  = 4'd11;

    logic [2:0]  r_state;
    logic [1:0]  r_phase;
    logic [15:0] r_pc;
    logic [7:0]  r_x;
    logic [7:0]  r_y;
    logic [7:0]  r_op;
    logic [3:0]  r_mode;
    logic [7:0]  r_lo;
    logic [7:0]  r_hi;
    logic [7:0]  r_plo;
    logic [7:0]  r_phi;

    logic [15:0] r_mem_addr;
    logic        r_mem_req;
    logic        r_ready;
    logic [7:0]  r_opcode;
    logic [15:0] r_addr_in;
    logic [15:0] r_pc_next;
    logic        r_imm;
    logic [3:0]  r_addr_mode;

    logic [3:0]  w_dec_mode;
    logic [2:0]  w_next_state;
    logic [15:0] w_rd_addr;
    logic [7:0]  w_zpx_ptr;
    logic [15:0] w_pc_next;
    logic [15:0] w_ea;

    // Opcode groups follow the 6502 aaa_bbb_cc layout; cc=11 has no legal opcodes.
    function automatic logic [3:0] decode_mode(input logic [7:0] op);
        logic [2:0] bbb;
        logic [3:0] m;
        bbb = op[4:2];
        m   = M_IMPL;
        case (op[1:0])
            2'b01: begin
                case (bbb)
                    3'd0: m = M_INDX;
                    3'd1: m = M_ZP;
                    3'd2: m = M_IMM;
                    3'd3: m = M_ABS;
                    3'd4: m = M_INDY;
                    3'd5: m = M_ZPX;
                    3'd6: m = M_ABSY;
                    3'd7: m = M_ABSX;
                endcase
            end
            2'b10: begin
                case (bbb)
                    3'd0: m = (op == 8'hA2) ? M_IMM : M_IMPL;
                    3'd1: m = M_ZP;
                    3'd2: m = M_IMPL;
                    3'd3: m = M_ABS;
                    3'd4: m = M_IMPL;
                    3'd5: m = ((op == 8'h96) || (op == 8'hB6)) ? M_ZPY : M_ZPX;
                    3'd6: m = M_IMPL;
                    3'd7: m = (op == 8'hBE) ? M_ABSY : M_ABSX;
                endcase
            end
            2'b00: begin
                case (bbb)
                    3'd0: begin
                        if ((op == 8'h00) || (op == 8'h40) || (op == 8'h60))
                            m = M_IMPL;
                        else if (op == 8'h20)
                            m = M_ABS;
                        else
                            m = M_IMM;
                    end
                    3'd1: m = M_ZP;
                    3'd2: m = M_IMPL;
                    3'd3: m = (op == 8'h6C) ? M_IND : M_ABS;
                    3'd4: m = M_REL;
                    3'd5: m = M_ZPX;
                    3'd6: m = M_IMPL;
                    3'd7: m = M_ABSX;
                endcase
            end
            default: m = M_IMPL;
        endcase
        return m;
    endfunction

    function automatic logic [1:0] operand_count(input logic [3:0] mode);
        logic [1:0] n;
        case (mode)
            M_IMPL:                        n = 2'd0;
            M_ABS, M_ABSX, M_ABSY, M_IND:  n = 2'd2;
            default:                       n = 2'd1;
        endcase
        return n;
    endfunction

    assign w_dec_mode = decode_mode(bus.mem_data_in);
    assign w_zpx_ptr  = r_lo + r_x;

    always_comb begin
        w_next_state = S_CALC;
        case (r_state)
            S_OP:     w_next_state = (operand_count(w_dec_mode) == 2'd0) ? S_CALC : S_OPR_LO;
            S_OPR_LO: begin
                if (operand_count(r_mode) == 2'd2)
                    w_next_state = S_OPR_HI;
                else if ((r_mode == M_INDX) || (r_mode == M_INDY))
                    w_next_state = S_PTR_LO;
                else
                    w_next_state = S_CALC;
            end
            S_OPR_HI: w_next_state = (r_mode == M_IND) ? S_PTR_LO : S_CALC;
            S_PTR_LO: w_next_state = S_PTR_HI;
            default:  w_next_state = S_CALC;
        endcase
    end

    // Pointer high-byte reads stay inside the pointer's page (zero page or JMP ind quirk).
    always_comb begin
        w_rd_addr = r_pc;
        case (r_state)
            S_OPR_LO: w_rd_addr = r_pc + 16'd1;
            S_OPR_HI: w_rd_addr = r_pc + 16'd2;
            S_PTR_LO: begin
                case (r_mode)
                    M_INDX:  w_rd_addr = {8'h00, w_zpx_ptr};
                    M_INDY:  w_rd_addr = {8'h00, r_lo};
                    default: w_rd_addr = {r_hi, r_lo};
                endcase
            end
            S_PTR_HI: begin
                case (r_mode)
                    M_INDX:  w_rd_addr = {8'h00, w_zpx_ptr + 8'd1};
                    M_INDY:  w_rd_addr = {8'h00, r_lo + 8'd1};
                    default: w_rd_addr = {r_hi, r_lo + 8'd1};
                endcase
            end
            default: w_rd_addr = r_pc;
        endcase
    end

    assign w_pc_next = r_pc + 16'd1 + {14'd0, operand_count(r_mode)};

    always_comb begin
        w_ea = 16'h0000;
        case (r_mode)
            M_IMM, M_ZP: w_ea = {8'h00, r_lo};
            M_ZPX:       w_ea = {8'h00, w_zpx_ptr};
            M_ZPY:       w_ea = {8'h00, r_lo + r_y};
            M_ABS:       w_ea = {r_hi, r_lo};
            M_ABSX:      w_ea = {r_hi, r_lo} + {8'h00, r_x};
            M_ABSY:      w_ea = {r_hi, r_lo} + {8'h00, r_y};
            M_INDX:      w_ea = {r_phi, r_plo};
            M_INDY:      w_ea = {r_phi, r_plo} + {8'h00, r_y};
            M_IND:       w_ea = {r_phi, r_plo};
            M_REL:       w_ea = w_pc_next + {{8{r_lo[7]}}, r_lo};
            default:     w_ea = 16'h0000;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_phase     <= P_ISSUE;
            r_pc        <= 16'h0000;
            r_x         <= 8'h00;
            r_y         <= 8'h00;
            r_op        <= 8'h00;
            r_mode      <= M_IMPL;
            r_lo        <= 8'h00;
            r_hi        <= 8'h00;
            r_plo       <= 8'h00;
            r_phi       <= 8'h00;
            r_mem_addr  <= 16'h0000;
            r_mem_req   <= 1'b0;
            r_ready     <= 1'b1;
            r_opcode    <= NOP_OPCODE;
            r_addr_in   <= 16'h0000;
            r_pc_next   <= RESET_PC;
            r_imm       <= 1'b0;
            r_addr_mode <= M_IMPL;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.if_start) begin
                        r_pc      <= bus.pc_in;
                        r_x       <= bus.x;
                        r_y       <= bus.y;
                        r_ready   <= 1'b0;
                        r_mem_req <= 1'b1;
                        r_phase   <= P_ISSUE;
                        r_state   <= S_OP;
                    end
                end
                S_CALC: begin
                    r_opcode    <= r_op;
                    r_addr_mode <= r_mode;
                    r_addr_in   <= w_ea;
                    r_pc_next   <= w_pc_next;
                    r_imm       <= (r_mode == M_IMM);
                    r_ready     <= 1'b1;
                    r_mem_req   <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: begin
                    case (r_phase)
                        P_ISSUE: begin
                            r_mem_addr <= w_rd_addr;
                            r_phase    <= P_WAIT;
                        end
                        P_WAIT: r_phase <= P_CAPTURE;
                        default: begin
                            case (r_state)
                                S_OP: begin
                                    r_op   <= bus.mem_data_in;
                                    r_mode <= w_dec_mode;
                                end
                                S_OPR_LO: r_lo  <= bus.mem_data_in;
                                S_OPR_HI: r_hi  <= bus.mem_data_in;
                                S_PTR_LO: r_plo <= bus.mem_data_in;
                                default:  r_phi <= bus.mem_data_in;
                            endcase
                            r_phase <= P_ISSUE;
                            r_state <= w_next_state;
                        end
                    endcase
                end
            endcase
        end
    end

    assign bus.mem_addr       = r_mem_addr;
    assign bus.mem_req        = r_mem_req;
    assign bus.if_ready       = r_ready;
    assign bus.opcode         = r_opcode;
    assign bus.if_addr_in     = r_addr_in;
    assign bus.if_pc_next     = r_pc_next;
    assign bus.immediate_flag = r_imm;
    assign bus.addr_mode      = r_addr_mode;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_fetch
// Brief    : Directed vectors plus random fetches against a mode-table model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_fetch;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    if_fetch_if bus ();

    if_fetch #(.RESET_PC(16'hFFFC), .NOP_OPCODE(8'hEA)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory returns data one edge after the address appears, so it is valid at edge N+2.
    logic [7:0] mem [0:65535];
    always @(posedge clk) bus.mem_data_in <= mem[bus.mem_addr];

    typedef struct {
        logic [7:0]       op;
        logic [3:0]       mode;
        logic [15:0]      ea;
        logic [15:0]      pcn;
        logic             imm;
        int               lat;
        int               nrd;
        logic [4:0][15:0] rd;
    } exp_t;

    typedef struct {
        logic [15:0] pc;
        logic [7:0]  x;
        logic [7:0]  y;
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
        logic [15:0] pa0;
        logic [7:0]  pd0;
        logic [15:0] pa1;
        logic [7:0]  pd1;
        exp_t        e;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    int          obs_lat;
    int          obs_n;
    logic [15:0] obs_rd [0:7];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic [15:0] pc, input logic [7:0] x, input logic [7:0] y,
        input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
        input logic [15:0] pa0, input logic [7:0] pd0,
        input logic [15:0] pa1, input logic [7:0] pd1,
        input logic [3:0] mode, input logic [15:0] ea, input logic [15:0] pcn,
        input logic imm, input int lat,
        input logic [15:0] r0, input logic [15:0] r1, input logic [15:0] r2,
        input logic [15:0] r3, input logic [15:0] r4);
        vec_t v;
        v.pc = pc;  v.x = x;  v.y = y;
        v.b0 = b0;  v.b1 = b1; v.b2 = b2;
        v.pa0 = pa0; v.pd0 = pd0; v.pa1 = pa1; v.pd1 = pd1;
        v.e.op   = b0;
        v.e.mode = mode;
        v.e.ea   = ea;
        v.e.pcn  = pcn;
        v.e.imm  = imm;
        v.e.lat  = lat;
        v.e.nrd  = (lat - 2) / 3;
        v.e.rd   = {r4, r3, r2, r1, r0};
        return v;
    endfunction

    function automatic int peek(input int a);
        logic [15:0] a16;
        a16 = a[15:0];
        return int'(mem[a16]);
    endfunction

    function automatic int ref_mode(input logic [7:0] op);
        int g01 [8];
        int g10 [8];
        int g00 [8];
        int b;
        int m;
        g01 = '{8, 2, 1, 5, 9, 3, 7, 6};
        g10 = '{1, 2, 0, 5, 0, 3, 0, 6};
        g00 = '{1, 2, 0, 5, 11, 3, 0, 6};
        b = int'(op[4:2]);
        case (op[1:0])
            2'b01:   m = g01[b];
            2'b10:   m = g10[b];
            2'b00:   m = g00[b];
            default: m = 0;
        endcase
        if (op[1:0] == 2'b10) begin
            if (b == 0 && op != 8'hA2) m = 0;
            if (op == 8'h96 || op == 8'hB6) m = 4;
            if (op == 8'hBE) m = 7;
        end
        if (op == 8'h00 || op == 8'h40 || op == 8'h60) m = 0;
        if (op == 8'h20) m = 5;
        if (op == 8'h6C) m = 10;
        return m;
    endfunction

    function automatic exp_t ref_fetch(input logic [15:0] pc, input logic [7:0] xv, input logic [7:0] yv);
        exp_t e;
        int   m, n, lo, hi, a1, a2, ea, ip;
        ip     = int'(pc);
        e.op   = mem[pc];
        m      = ref_mode(e.op);
        e.mode = m[3:0];
        n      = (m == 0) ? 0 : (m == 5 || m == 6 || m == 7 || m == 10) ? 2 : 1;
        lo     = peek(ip + 1);
        hi     = peek(ip + 2);
        e.pcn  = 16'((ip + 1 + n) % 65536);
        e.imm  = (m == 1);
        e.rd   = '0;
        e.rd[0] = pc;
        e.rd[1] = 16'((ip + 1) % 65536);
        e.rd[2] = 16'((ip + 2) % 65536);
        e.nrd  = 1 + n;
        a1 = 0; a2 = 0; ea = 0;
        case (m)
            1, 2: ea = lo;
            3:    ea = (lo + int'(xv)) % 256;
            4:    ea = (lo + int'(yv)) % 256;
            5:    ea = hi * 256 + lo;
            6:    ea = (hi * 256 + lo + int'(xv)) % 65536;
            7:    ea = (hi * 256 + lo + int'(yv)) % 65536;
            8:    begin a1 = (lo + int'(xv)) % 256; a2 = (a1 + 1) % 256; end
            9:    begin a1 = lo; a2 = (lo + 1) % 256; end
            10:   begin a1 = hi * 256 + lo; a2 = hi * 256 + (lo + 1) % 256; end
            11:   ea = (ip + 1 + n + ((lo < 128) ? lo : lo - 256) + 65536) % 65536;
            default: ea = 0;
        endcase
        if (m >= 8 && m <= 10) begin
            e.rd[e.nrd]     = 16'(a1);
            e.rd[e.nrd + 1] = 16'(a2);
            e.nrd += 2;
            ea = peek(a2) * 256 + peek(a1);
            if (m == 9) ea = (ea + int'(yv)) % 65536;
        end
        e.ea  = 16'(ea);
        e.lat = 3 * e.nrd + 2;
        return e;
    endfunction

    // Latency counts posedges from the one that samples if_start to the one raising if_ready.
    task automatic run_fetch(input logic [15:0] pc, input logic [7:0] xv, input logic [7:0] yv, input bit glitch);
        int cyc;
        @(negedge clk);
        bus.pc_in    = pc;
        bus.x        = xv;
        bus.y        = yv;
        bus.if_start = 1'b1;
        @(negedge clk);
        bus.if_start = 1'b0;
        cyc   = 1;
        obs_n = 0;
        chk("busy_after_start", {bus.if_ready, bus.mem_req}, 2'b01);
        while (!bus.if_ready && cyc < 60) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (glitch && cyc == 4) begin
                bus.if_start = 1'b1;
                bus.pc_in    = pc ^ 16'h5555;
            end else begin
                bus.if_start = 1'b0;
            end
            if (((cyc - 2) % 3 == 0) && obs_n < 8 && !bus.if_ready) begin
                obs_rd[obs_n] = bus.mem_addr;
                obs_n++;
            end
        end
        bus.if_start = 1'b0;
        obs_lat = cyc;
        if (!bus.if_ready) chk("ready_timeout", 64'd0, 64'd1);
    endtask

    task automatic compare(input exp_t e);
        chk("opcode", bus.opcode, e.op);
        chk("addr_mode", bus.addr_mode, e.mode);
        chk("if_addr_in", bus.if_addr_in, e.ea);
        chk("if_pc_next", bus.if_pc_next, e.pcn);
        chk("immediate_flag", bus.immediate_flag, e.imm);
        chk("latency", 64'(obs_lat), 64'(e.lat));
        chk("mem_req_released", bus.mem_req, 1'b0);
        chk("read_count", 64'(obs_n), 64'(e.nrd));
        for (int i = 0; i < e.nrd && i < obs_n; i++)
            chk("read_addr", obs_rd[i], e.rd[i]);
        repeat (2) @(negedge clk);
        chk("hold", {bus.if_ready, bus.if_addr_in, bus.if_pc_next, bus.opcode},
                    {1'b1, e.ea, e.pcn, e.op});
    endtask

    task automatic chk_reset();
        chk("rst_if_ready", bus.if_ready, 1'b1);
        chk("rst_opcode", bus.opcode, 8'hEA);
        chk("rst_if_pc_next", bus.if_pc_next, 16'hFFFC);
        chk("rst_if_addr_in", bus.if_addr_in, 16'h0000);
        chk("rst_immediate_flag", bus.immediate_flag, 1'b0);
        chk("rst_addr_mode", bus.addr_mode, 4'd0);
        chk("rst_mem_addr", bus.mem_addr, 16'h0000);
        chk("rst_mem_req", bus.mem_req, 1'b0);
    endtask

    task automatic load_vec(input vec_t v);
        mem[v.pc]          = v.b0;
        mem[v.pc + 16'd1]  = v.b1;
        mem[v.pc + 16'd2]  = v.b2;
        mem[v.pa0]         = v.pd0;
        mem[v.pa1]         = v.pd1;
    endtask

    initial begin
        exp_t        e;
        logic [15:0] rpc;
        logic [7:0]  rx, ry;

        total = 0;
        bad   = 0;
        rst   = 1'b0;
        bus.if_start = 1'b0;
        bus.pc_in    = 16'h0000;
        bus.x        = 8'h00;
        bus.y        = 8'h00;
        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);

        //         pc      x      y      b0     b1     b2     pa0       pd0    pa1       pd1    md     ea        pcn       imm  lat  reads
        vecs[0]  = mk(16'h8000, 8'h00, 8'h00, 8'hE8, 8'h00, 8'h00, 16'h7000, 8'h00, 16'h7001, 8'h00, 4'd0,  16'h0000, 16'h8001, 1'b0, 5,
                      16'h8000, 16'h0, 16'h0, 16'h0, 16'h0);
        vecs[1]  = mk(16'h0200, 8'h20, 8'h00, 8'hBD, 8'hF0, 8'h12, 16'h7000, 8'h00, 16'h7001, 8'h00, 4'd6,  16'h1310, 16'h0203, 1'b0, 11,
                      16'h0200, 16'h0201, 16'h0202, 16'h0, 16'h0);
        vecs[2]  = mk(16'h0200, 8'h01, 8'h00, 8'hBD, 8'hFF, 8'hFF, 16'h7000, 8'h00, 16'h7001, 8'h00, 4'd6,  16'h0000, 16'h0203, 1'b0, 11,
                      16'h0200, 16'h0201, 16'h0202, 16'h0, 16'h0);
        vecs[3]  = mk(16'h0300, 8'h00, 8'h10, 8'hB1, 8'hFF, 8'h00, 16'h00FF, 8'h34, 16'h0000, 8'h12, 4'd9,  16'h1244, 16'h0302, 1'b0, 14,
                      16'h0300, 16'h0301, 16'h00FF, 16'h0000, 16'h0);
        vecs[4]  = mk(16'h0400, 8'h00, 8'h00, 8'h6C, 8'hFF, 8'h30, 16'h30FF, 8'h80, 16'h3000, 8'h50, 4'd10, 16'h5080, 16'h0403, 1'b0, 17,
                      16'h0400, 16'h0401, 16'h0402, 16'h30FF, 16'h3000);
        vecs[5]  = mk(16'h0500, 8'h00, 8'h00, 8'hD0, 8'hFC, 8'h00, 16'h7000, 8'h00, 16'h7001, 8'h00, 4'd11, 16'h04FE, 16'h0502, 1'b0, 8,
                      16'h0500, 16'h0501, 16'h0, 16'h0, 16'h0);
        vecs[6]  = mk(16'h0500, 8'h00, 8'h00, 8'hA9, 8'h7F, 8'h00, 16'h7000, 8'h00, 16'h7001, 8'h00, 4'd1,  16'h007F, 16'h0502, 1'b1, 8,
                      16'h0500, 16'h0501, 16'h0, 16'h0, 16'h0);
        vecs[7]  = mk(16'h0600, 8'h0F, 8'h00, 8'hA1, 8'hF0, 8'h00, 16'h00FF, 8'hCD, 16'h0000, 8'hAB, 4'd8,  16'hABCD, 16'h0602, 1'b0, 14,
                      16'h0600, 16'h0601, 16'h00FF, 16'h0000, 16'h0);
        vecs[8]  = mk(16'h0700, 8'h20, 8'h00, 8'hB5, 8'hF0, 8'h00, 16'h7000, 8'h00, 16'h7001, 8'h00, 4'd3,  16'h0010, 16'h0702, 1'b0, 8,
                      16'h0700, 16'h0701, 16'h0, 16'h0, 16'h0);
        vecs[9]  = mk(16'h0710, 8'h00, 8'h90, 8'hB6, 8'h80, 8'h00, 16'h7000, 8'h00, 16'h7001, 8'h00, 4'd4,  16'h0010, 16'h0712, 1'b0, 8,
                      16'h0710, 16'h0711, 16'h0, 16'h0, 16'h0);
        vecs[10] = mk(16'h0720, 8'h00, 8'h00, 8'h20, 8'h34, 8'h12, 16'h7000, 8'h00, 16'h7001, 8'h00, 4'd5,  16'h1234, 16'h0723, 1'b0, 11,
                      16'h0720, 16'h0721, 16'h0722, 16'h0, 16'h0);
        vecs[11] = mk(16'h0730, 8'h00, 8'h00, 8'hA2, 8'h05, 8'h00, 16'h7000, 8'h00, 16'h7001, 8'h00, 4'd1,  16'h0005, 16'h0732, 1'b1, 8,
                      16'h0730, 16'h0731, 16'h0, 16'h0, 16'h0);
        vecs[12] = mk(16'h0740, 8'h00, 8'h05, 8'hBE, 8'h00, 8'h20, 16'h7000, 8'h00, 16'h7001, 8'h00, 4'd7,  16'h2005, 16'h0743, 1'b0, 11,
                      16'h0740, 16'h0741, 16'h0742, 16'h0, 16'h0);
        vecs[13] = mk(16'h0750, 8'h00, 8'h00, 8'h60, 8'h11, 8'h22, 16'h7000, 8'h00, 16'h7001, 8'h00, 4'd0,  16'h0000, 16'h0751, 1'b0, 5,
                      16'h0750, 16'h0, 16'h0, 16'h0, 16'h0);
        vecs[14] = mk(16'hFFFF, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 16'h7000, 8'h00, 16'h7001, 8'h00, 4'd0,  16'h0000, 16'h0000, 1'b0, 5,
                      16'hFFFF, 16'h0, 16'h0, 16'h0, 16'h0);

        repeat (3) @(negedge clk);
        chk_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_reset();

        for (int i = 0; i < NV; i++) begin
            load_vec(vecs[i]);
            run_fetch(vecs[i].pc, vecs[i].x, vecs[i].y, 1'b0);
            compare(vecs[i].e);
        end

        // Reset asserted while the (ind,X) pointer-low read is in flight.
        load_vec(vecs[7]);
        @(negedge clk);
        bus.pc_in    = 16'h0600;
        bus.x        = 8'h0F;
        bus.if_start = 1'b1;
        @(negedge clk);
        bus.if_start = 1'b0;
        repeat (7) @(negedge clk);
        chk("pre_reset_ptr_lo", {bus.if_ready, bus.mem_req, bus.mem_addr}, {1'b0, 1'b1, 16'h00FF});
        rst = 1'b0;
        #1;
        chk_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_reset_idle", {bus.if_ready, bus.mem_req}, 2'b10);

        // A start pulse in mid-fetch must not disturb the fetch in progress.
        load_vec(vecs[1]);
        run_fetch(vecs[1].pc, vecs[1].x, vecs[1].y, 1'b1);
        compare(vecs[1].e);

        for (int i = 0; i < 60; i++) begin
            rpc = 16'($urandom);
            mem[rpc] = 8'($urandom);
            rx = 8'($urandom);
            ry = 8'($urandom);
            e = ref_fetch(rpc, rx, ry);
            run_fetch(rpc, rx, ry, 1'b0);
            compare(e);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
